dccm_arbiter: RTL and testbench
===============================

# dccm_arbiter

Shares the single-port DCCM word memory between the core load/store unit (LSU) and a DMA/debug requester. The arbiter sits directly in front of `dccm_mem`. Each cycle it grants at most one request and drives the memory's read/write enables, addresses and write data. It returns read data to the winning requester one cycle later, as required by the synchronous-read macro. Arbitration uses LSU priority, with a starvation counter that guarantees DMA forward progress.

## Interface
Parameters:
- `AW`, 32, address width; word address, passed to the memory unchanged.
- `DW`, 32, data width.
- `STARVE_MAX`, 4, number of consecutive blocked DMA cycles after which DMA wins over LSU; legal range 1..15.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `lsu_req_valid` in 1: LSU request present.
- `lsu_req_we` in 1: 1 = write, 0 = read.
- `lsu_req_addr` in AW: word address.
- `lsu_req_wdata` in DW: write data.
- `lsu_req_ready` out 1: LSU request accepted this cycle.
- `lsu_rsp_valid` out 1: LSU read data valid.
- `lsu_rsp_rdata` out DW: LSU read data.
- `dma_req_valid`, `dma_req_we`, `dma_req_addr`, `dma_req_wdata`, `dma_req_ready`, `dma_rsp_valid`, `dma_rsp_rdata`: same as the LSU set, for DMA.
- `dccm_wr_en` out 1: memory write enable.
- `dccm_rd_en` out 1: memory read enable.
- `dccm_wr_addr` out AW: memory write address.
- `dccm_rd_addr` out AW: memory read address.
- `dccm_wr_data` out DW: memory write data.
- `dccm_rd_data` in DW: memory read data, valid one cycle after the read address is presented.

## Operation
- **Grant (combinational):**
  - DMA wins if `dma_req_valid` and (`!lsu_req_valid` or `starve_cnt == STARVE_MAX`).
  - Otherwise LSU wins if `lsu_req_valid`.
  - Otherwise nothing is granted.
- **Handshake:** `x_req_ready` = grant to x. A request transfers when valid && ready. Requesters must hold address, data and `we` stable while valid && !ready.
- **Memory drive:** on a granted write, `dccm_wr_en`=1, `dccm_rd_en`=0. On a granted read, `dccm_rd_en`=1, `dccm_wr_en`=0. Both address outputs carry the granted address; `dccm_wr_data` carries the granted wdata. With no grant, both enables are 0 and the address/data outputs are 0.
- **Starvation counter `starve_cnt` (4 bits):**
  - Increments when `dma_req_valid` && !dma grant, saturating at `STARVE_MAX`.
  - Clears on a DMA grant or when `dma_req_valid` = 0.
- **Response pipeline:**
  - Registers `rsp_pend` (1 bit) and `rsp_owner` (0 = LSU, 1 = DMA) on every granted read.
  - Next cycle, the owner's `rsp_valid` = 1 and its `rsp_rdata` = `dccm_rd_data`. The other requester's `rsp_valid` = 0 and its `rsp_rdata` = 0.
  - Writes produce no response.
- Back-to-back reads are fully pipelined: one grant per cycle, one response per cycle.
- Same-cycle write-then-read to the same address from different requesters is impossible, because only one grant is issued per cycle. A read granted the cycle after a write returns the new data.

## Timing
- **Reset values:** `starve_cnt`=0, `rsp_pend`=0, `rsp_owner`=0. All `rsp_valid`=0 and all memory enables=0 while `rst_n`=0.
- **Latencies:** request-to-ready is 0 cycles. Read grant to `rsp_valid` is exactly 1 cycle. A write is committed at the grant edge.
- **Reset asserted mid-operation:** any pending response is dropped with no `rsp_valid`. Arbitration restarts with LSU priority and counter 0.
- **Simultaneous requests with counter at max:** DMA is granted and the counter clears that edge. LSU is held off for exactly one cycle.
- **`STARVE_MAX` reached with LSU idle:** normal DMA grant; no special case.

## Structure
- Shared package `dccm_pkg`:
  - Requester id constants `REQ_LSU`=1'b0 and `REQ_DMA`=1'b1.
  - Default `STARVE_MAX`.
  - The widths `AW`/`DW` shared with `dccm_mem`.
- One sub-module, `dccm_prio_sel`: the combinational grant logic plus the saturating starvation counter. It outputs `gnt_lsu` and `gnt_dma`.
- The top level handles the memory mux and the response pipeline.

## Test plan
- **LSU write then read:** LSU writes 0xDEADBEEF to addr 0x10, then reads 0x10. Expect `dccm_wr_en`=1 in cycle 0, `lsu_rsp_valid`=1 in cycle 2 with rdata 0xDEADBEEF, and `dma_rsp_valid`=0 throughout.
- **LSU priority:** LSU and DMA both valid, reading 0x20 and 0x30. LSU is granted in cycle 0 and DMA `ready`=0.
- **Starvation:** LSU valid continuously and DMA valid continuously, with `STARVE_MAX`=4. DMA is blocked for cycles 0–3 and granted in cycle 4. LSU `ready`=0 in cycle 4, and the counter reads 0 in cycle 5.
- **Interleaved reads:** back-to-back reads LSU@0x1, DMA@0x2, LSU@0x3 with memory preloaded 0xA/0xB/0xC. Responses arrive on consecutive cycles and are steered correctly to LSU/DMA/LSU.
- **Reset mid-read:** grant an LSU read, then assert `rst_n`=0 before the next edge. No `lsu_rsp_valid` appears, and `starve_cnt`=0 after release.
- **Idle:** with no valids for 10 cycles, all enables, addresses and `rsp_valid` outputs stay 0.

Source files
------------

// File: rtl/dccm_pkg.sv
// Shared constants for the DCCM arbiter and the DCCM memory macro.
package dccm_pkg;
    localparam int DCCM_AW        = 32;
    localparam int DCCM_DW        = 32;
    localparam int STARVE_MAX_DEF = 4;

    localparam logic REQ_LSU = 1'b0;
    localparam logic REQ_DMA = 1'b1;
endpackage

// File: rtl/dccm_prio_sel.sv
// LSU-priority grant selection with a saturating DMA starvation counter.
module dccm_prio_sel
    import dccm_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lsu_valid,
    input  logic dma_valid,
    output logic gnt_lsu,
    output logic gnt_dma
);
    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    // Grants are gated by reset so the memory sees no enables while held.
    always_comb begin
        gnt_dma = rst_n && dma_valid && (!lsu_valid || starve_cnt == CNT_MAX);
        gnt_lsu = rst_n && lsu_valid && !gnt_dma;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (!dma_valid || gnt_dma) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
endmodule

// File: rtl/dccm_arbiter.sv
// Shares the single-port DCCM between LSU and DMA/debug; one grant per cycle,
// read data steered back to the winner one cycle after the grant.
module dccm_arbiter
    import dccm_pkg::*;
#(
    parameter int AW         = DCCM_AW,
    parameter int DW         = DCCM_DW,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lsu_req_valid,
    input  logic          lsu_req_we,
    input  logic [AW-1:0] lsu_req_addr,
    input  logic [DW-1:0] lsu_req_wdata,
    output logic          lsu_req_ready,
    output logic          lsu_rsp_valid,
    output logic [DW-1:0] lsu_rsp_rdata,
    input  logic          dma_req_valid,
    input  logic          dma_req_we,
    input  logic [AW-1:0] dma_req_addr,
    input  logic [DW-1:0] dma_req_wdata,
    output logic          dma_req_ready,
    output logic          dma_rsp_valid,
    output logic [DW-1:0] dma_rsp_rdata,
    output logic          dccm_wr_en,
    output logic          dccm_rd_en,
    output logic [AW-1:0] dccm_wr_addr,
    output logic [AW-1:0] dccm_rd_addr,
    output logic [DW-1:0] dccm_wr_data,
    input  logic [DW-1:0] dccm_rd_data
);
    logic gnt_lsu, gnt_dma;
    logic rsp_pend, rsp_owner;

    dccm_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_prio_sel (
        .clk       (clk),
        .rst_n     (rst_n),
        .lsu_valid (lsu_req_valid),
        .dma_valid (dma_req_valid),
        .gnt_lsu   (gnt_lsu),
        .gnt_dma   (gnt_dma)
    );

    assign lsu_req_ready = gnt_lsu;
    assign dma_req_ready = gnt_dma;

    always_comb begin
        dccm_wr_en   = 1'b0;
        dccm_rd_en   = 1'b0;
        dccm_wr_addr = '0;
        dccm_rd_addr = '0;
        dccm_wr_data = '0;
        if (gnt_dma) begin
            dccm_wr_en   = dma_req_we;
            dccm_rd_en   = !dma_req_we;
            dccm_wr_addr = dma_req_addr;
            dccm_rd_addr = dma_req_addr;
            dccm_wr_data = dma_req_wdata;
        end else if (gnt_lsu) begin
            dccm_wr_en   = lsu_req_we;
            dccm_rd_en   = !lsu_req_we;
            dccm_wr_addr = lsu_req_addr;
            dccm_rd_addr = lsu_req_addr;
            dccm_wr_data = lsu_req_wdata;
        end
    end

    // Owner only tracks reads; writes never return a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend  <= 1'b0;
            rsp_owner <= REQ_LSU;
        end else begin
            rsp_pend <= dccm_rd_en;
            if (dccm_rd_en)
                rsp_owner <= gnt_dma ? REQ_DMA : REQ_LSU;
        end
    end

    always_comb begin
        lsu_rsp_valid = rsp_pend && (rsp_owner == REQ_LSU);
        dma_rsp_valid = rsp_pend && (rsp_owner == REQ_DMA);
        lsu_rsp_rdata = lsu_rsp_valid ? dccm_rd_data : '0;
        dma_rsp_rdata = dma_rsp_valid ? dccm_rd_data : '0;
    end
endmodule

// File: tb/tb_dccm_arbiter.sv
// Directed checks of dccm_arbiter against a behavioural synchronous-read DCCM.
module tb_dccm_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
    logic        dma_req_valid, dma_req_we, dma_req_ready, dma_rsp_valid;
    logic [31:0] dma_req_addr, dma_req_wdata, dma_rsp_rdata;
    logic        dccm_wr_en, dccm_rd_en;
    logic [31:0] dccm_wr_addr, dccm_rd_addr, dccm_wr_data, dccm_rd_data;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dccm_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_we    (lsu_req_we),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .dma_req_valid (dma_req_valid),
        .dma_req_we    (dma_req_we),
        .dma_req_addr  (dma_req_addr),
        .dma_req_wdata (dma_req_wdata),
        .dma_req_ready (dma_req_ready),
        .dma_rsp_valid (dma_rsp_valid),
        .dma_rsp_rdata (dma_rsp_rdata),
        .dccm_wr_en    (dccm_wr_en),
        .dccm_rd_en    (dccm_rd_en),
        .dccm_wr_addr  (dccm_wr_addr),
        .dccm_rd_addr  (dccm_rd_addr),
        .dccm_wr_data  (dccm_wr_data),
        .dccm_rd_data  (dccm_rd_data)
    );

    always @(posedge clk) begin
        if (dccm_wr_en) mem[dccm_wr_addr[7:0]] <= dccm_wr_data;
        if (dccm_rd_en) dccm_rd_data <= mem[dccm_rd_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic lsu(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        lsu_req_valid = v; lsu_req_we = we; lsu_req_addr = a; lsu_req_wdata = d;
    endtask

    task automatic dma(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        dma_req_valid = v; dma_req_we = we; dma_req_addr = a; dma_req_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1] = 32'hA; mem[2] = 32'hB; mem[3] = 32'hC;
        mem[8'h20] = 32'h2020_2020; mem[8'h30] = 32'h3030_3030;
        dccm_rd_data = 32'h0;
        rst_n = 1'b0;
        lsu(1'b1, 1'b0, 32'h10, 32'h0);
        dma(1'b1, 1'b0, 32'h30, 32'h0);

        // Requests present during reset must not reach the memory
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", dccm_rd_en, 1'b0);
        chk("rst_ready", {lsu_req_ready, dma_req_ready}, 2'b00);
        chk("rst_rsp_valid", {lsu_rsp_valid, dma_rsp_valid}, 2'b00);
        chk("rst_cnt", dut.u_prio_sel.starve_cnt, 4'd0);
        nxt();
        lsu(1'b0, 1'b0, 32'h0, 32'h0);
        dma(1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // LSU write then read
        nxt();
        lsu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_en", {dccm_wr_en, dccm_rd_en, lsu_req_ready}, 3'b101);
        chk("wr_addr_data", {dccm_wr_addr, dccm_wr_data}, {32'h10, 32'hDEADBEEF});
        chk("wr_no_dma_rsp", dma_rsp_valid, 1'b0);
        nxt();
        lsu(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("rd_en", {dccm_wr_en, dccm_rd_en, dccm_rd_addr}, {2'b01, 32'h10});
        chk("wr_no_rsp", {lsu_rsp_valid, dma_rsp_valid}, 2'b00);
        nxt();
        lsu(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("raw_rsp", {lsu_rsp_valid, lsu_rsp_rdata}, {1'b1, 32'hDEADBEEF});
        chk("raw_dma_quiet", {dma_rsp_valid, dma_rsp_rdata}, 33'h0);

        // LSU priority, then starvation with both held valid
        nxt();
        lsu(1'b1, 1'b0, 32'h20, 32'h0);
        dma(1'b1, 1'b0, 32'h30, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("starve_c%0d_ready", c), {lsu_req_ready, dma_req_ready}, 2'b10);
            chk($sformatf("starve_c%0d_cnt", c), dut.u_prio_sel.starve_cnt, 4'(c));
            if (c == 0) chk("prio_rd_addr", dccm_rd_addr, 32'h20);
            else chk($sformatf("starve_c%0d_lsu_rsp", c), {lsu_rsp_valid, lsu_rsp_rdata}, {1'b1, 32'h2020_2020});
            nxt();
        end
        @(negedge clk);
        chk("starve_c4_ready", {lsu_req_ready, dma_req_ready}, 2'b01);
        chk("starve_c4_addr", {dccm_rd_en, dccm_rd_addr}, {1'b1, 32'h30});
        nxt();
        @(negedge clk);
        chk("starve_c5_cnt", dut.u_prio_sel.starve_cnt, 4'd0);
        chk("starve_c5_ready", {lsu_req_ready, dma_req_ready}, 2'b10);
        chk("starve_c5_dma_rsp", {dma_rsp_valid, dma_rsp_rdata, lsu_rsp_valid}, {1'b1, 32'h3030_3030, 1'b0});

        // Interleaved reads LSU / DMA / LSU
        nxt();
        lsu(1'b1, 1'b0, 32'h1, 32'h0);
        dma(1'b0, 1'b0, 32'h0, 32'h0);
        nxt();
        lsu(1'b0, 1'b0, 32'h0, 32'h0);
        dma(1'b1, 1'b0, 32'h2, 32'h0);
        @(negedge clk);
        chk("il_dma_ready", dma_req_ready, 1'b1);
        chk("il_rsp0", {lsu_rsp_valid, lsu_rsp_rdata, dma_rsp_valid}, {1'b1, 32'hA, 1'b0});
        nxt();
        lsu(1'b1, 1'b0, 32'h3, 32'h0);
        dma(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("il_rsp1", {dma_rsp_valid, dma_rsp_rdata, lsu_rsp_valid}, {1'b1, 32'hB, 1'b0});
        nxt();
        lsu(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("il_rsp2", {lsu_rsp_valid, lsu_rsp_rdata, dma_rsp_valid}, {1'b1, 32'hC, 1'b0});

        // Reset mid-read with the counter already advanced
        nxt();
        lsu(1'b1, 1'b0, 32'h10, 32'h0);
        dma(1'b1, 1'b0, 32'h30, 32'h0);
        nxt();
        @(negedge clk);
        chk("mrst_pre_cnt", dut.u_prio_sel.starve_cnt, 4'd1);
        chk("mrst_pre_rd", {dccm_rd_en, lsu_req_ready}, 2'b11);
        #2;
        rst_n = 1'b0;
        lsu(1'b0, 1'b0, 32'h0, 32'h0);
        dma(1'b0, 1'b0, 32'h0, 32'h0);
        nxt();
        @(negedge clk);
        chk("mrst_no_rsp", {lsu_rsp_valid, dma_rsp_valid, dccm_rd_en}, 3'b000);
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_post_cnt", dut.u_prio_sel.starve_cnt, 4'd0);
        chk("mrst_post_rsp", lsu_rsp_valid, 1'b0);
        nxt();
        lsu(1'b1, 1'b0, 32'h20, 32'h0);
        dma(1'b1, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        chk("mrst_lsu_prio", {lsu_req_ready, dma_req_ready}, 2'b10);

        // Idle: everything quiet for 10 cycles
        nxt();
        lsu(1'b0, 1'b0, 32'h0, 32'h0);
        dma(1'b0, 1'b0, 32'h0, 32'h0);
        nxt();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle_c%0d", c),
                {dccm_wr_en, dccm_rd_en, dccm_wr_addr, dccm_rd_addr, dccm_wr_data,
                 lsu_rsp_valid, dma_rsp_valid, lsu_req_ready, dma_req_ready}, '0);
            nxt();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
